// File: rtl/fm_exciter_if.sv
`timescale 1ns/1ps
// fm_exciter_if: control, audio push channel and RF output bundle of fm_exciter.
// The master drives carrier control and audio; the slave (the exciter) returns rf/status.
interface fm_exciter_if #(
   parameter int A = 8,
   parameter int K = 4,
   parameter int N = 18,
   parameter int D = 5
);
   logic         enable;
   logic         sample_tick;
   logic [A-1:0] audio_data;
   logic         audio_valid;
   logic         audio_ready;
   logic [N-1:0] acc_inc;
   logic         tune_load;
   logic [K-1:0] df_coef;
   logic [1:0]   df_shift;
   logic [D-1:0] rf;
   logic         busy;
   logic         underflow;

   modport master (
      output enable, sample_tick, audio_data, audio_valid,
             acc_inc, tune_load, df_coef, df_shift,
      input  audio_ready, rf, busy, underflow
   );

   modport slave (
      input  enable, sample_tick, audio_data, audio_valid,
             acc_inc, tune_load, df_coef, df_shift,
      output audio_ready, rf, busy, underflow
   );
endinterface

// File: rtl/fm_exciter.sv
`timescale 1ns/1ps
// fm_exciter: audio FIFO + frequency-modulated phase accumulator + piecewise sine,
// with a linear amplitude ramp on carrier on/off. Optional macro: FM_EXCITER_PREEMPH_EN.
module fm_exciter #(
   parameter int A     = 8,
   parameter int K     = 4,
   parameter int N     = 18,
   parameter int M     = 14,
   parameter int D     = 5,
   parameter int G     = 4,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   fm_exciter_if.slave   bus
);
   localparam int R  = M - 2;
   localparam int AW = $clog2(DEPTH);
   localparam logic [G:0]   AMP_FULL = (G+1)'(1 << G);
   localparam logic [D-1:0] RF_MID   = D'(1 << (D-1));
   localparam logic [D-2:0] MAG_MID  = (D-1)'(1 << (D-3));

   typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;

   state_t         state_q;
   logic [G:0]     amp_q;
   logic           busy_q;
   logic           underflow_q;

   logic [A-1:0]   mem_q [DEPTH];
   logic [AW-1:0]  wrPtr_q, rdPtr_q;
   logic [AW:0]    count_q;
   logic           fifoFull, fifoEmpty, push, popReq, pop;

   logic [A-1:0]   sample_q, sample_d;
   logic [N-1:0]   phase_q, phase_d;
   logic [N-1:0]   incActive_q, incActive_d;
   logic [N-1:0]   incPending_q, incPending_d;
   logic [D-1:0]   rf_q, rf_d;

   logic [A+K:0]   sampExt, coefExt, prod;
   logic [N-1:0]   devExt, dev;
   logic [N+1:0]   sumExt;
   logic           wrap;

   logic [1:0]     quad;
   logic [R-1:0]   rRaw, folded;
   logic [D-2:0]   tVal, mag;
   logic [1:0]     sVal;
   logic [D+G-1:0] ampProd;
   logic [D-1:0]   scaled;

   assign fifoFull  = (count_q == (AW+1)'(DEPTH));
   assign fifoEmpty = (count_q == '0);
   assign push      = bus.audio_valid && !fifoFull;
   assign popReq    = bus.sample_tick && (state_q != IDLE);
   assign pop       = popReq && !fifoEmpty;

   assign bus.audio_ready = !fifoFull;
   assign bus.rf          = rf_q;
   assign bus.busy        = busy_q;
   assign bus.underflow   = underflow_q;

   // Ramp FSM; underflow is cleared on every entry to RAMP_UP, a same-cycle empty pop re-sets it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         amp_q       <= '0;
         busy_q      <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               amp_q <= '0;
               if (bus.enable) begin
                  state_q     <= RAMP_UP;
                  busy_q      <= 1'b1;
                  underflow_q <= 1'b0;
               end
            end
            RAMP_UP: begin
               if (!bus.enable) begin
                  state_q <= RAMP_DOWN;
               end else begin
                  amp_q <= amp_q + 1'b1;
                  if (amp_q == AMP_FULL - 1'b1) state_q <= RUN;
               end
            end
            RUN: begin
               amp_q <= AMP_FULL;
               if (!bus.enable) state_q <= RAMP_DOWN;
            end
            RAMP_DOWN: begin
               if (bus.enable) begin
                  state_q     <= RAMP_UP;
                  underflow_q <= 1'b0;
               end else if (amp_q <= (G+1)'(1)) begin
                  amp_q   <= '0;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  amp_q <= amp_q - 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               amp_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
         if (popReq && fifoEmpty) underflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push) wrPtr_q <= wrPtr_q + 1'b1;
         if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wrPtr_q] <= bus.audio_data;
   end

`ifdef FM_EXCITER_PREEMPH_EN
   logic [A-1:0]        xPrev_q;
   logic [A-1:0]        xPop;
   logic signed [A:0]   diff, half;
   logic [A+1:0]        emph;
   logic [A-1:0]        emphSat;

   // Pre-emphasis boosts the audio slope: x + (x - x_prev)/2, clipped to the sample range.
   always_comb begin
      xPop = mem_q[rdPtr_q];
      diff = $signed({xPop[A-1], xPop}) - $signed({xPrev_q[A-1], xPrev_q});
      half = diff >>> 1;
      emph = {{2{xPop[A-1]}}, xPop} + {half[A], half};
      if (emph[A+1:A-1] == 3'b000 || emph[A+1:A-1] == 3'b111) begin
         emphSat = emph[A-1:0];
      end else if (emph[A+1]) begin
         emphSat = {1'b1, {(A-1){1'b0}}};
      end else begin
         emphSat = {1'b0, {(A-1){1'b1}}};
      end
      sample_d = pop ? emphSat : sample_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      xPrev_q <= '0;
      else if (pop) xPrev_q <= xPop;
   end
`else
   always_comb begin
      sample_d = pop ? mem_q[rdPtr_q] : sample_q;
   end
`endif

   // Deviation and phase step; a wrap (carry past 2^N) is where a pending tune takes effect.
   always_comb begin
      sampExt      = {{(K+1){sample_q[A-1]}}, sample_q};
      coefExt      = {{A{1'b0}}, bus.df_coef};
      prod         = sampExt * coefExt;
      devExt       = {{(N-A-K-1){prod[A+K]}}, prod};
      dev          = devExt << bus.df_shift;
      sumExt       = {2'b00, phase_q} + {2'b00, incActive_q} + {2'b00, dev};
      wrap         = (state_q != IDLE) && (sumExt[N+1:N] != 2'b00);
      phase_d      = (state_q == IDLE) ? '0 : sumExt[N-1:0];
      incPending_d = bus.tune_load ? bus.acc_inc : incPending_q;
      incActive_d  = incActive_q;
      if (state_q == IDLE) begin
         incActive_d = incPending_q;
      end else if (wrap) begin
         incActive_d = bus.tune_load ? bus.acc_inc : incPending_q;
      end
   end

   // Quarter-wave folded sine: three-segment magnitude, mirrored by quadrant, scaled by amp.
   always_comb begin
      quad    = phase_q[N-1:N-2];
      rRaw    = phase_q[N-3:N-2-R];
      folded  = quad[0] ? ~rRaw : rRaw;
      tVal    = (D-1)'(folded >> (R-D+1));
      sVal    = 2'(folded >> (R-2));
      case (sVal)
         2'd0:    mag = {tVal[D-3:0], 1'b0};
         2'd3:    mag = '1;
         default: mag = MAG_MID + tVal;
      endcase
      ampProd = {{(G+1){1'b0}}, mag} * {{(D-1){1'b0}}, amp_q};
      scaled  = D'(ampProd >> G);
      rf_d    = quad[1] ? (RF_MID - scaled) : (RF_MID + scaled);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_q     <= '0;
         phase_q      <= '0;
         incActive_q  <= '0;
         incPending_q <= '0;
         rf_q         <= RF_MID;
      end else begin
         sample_q     <= sample_d;
         phase_q      <= phase_d;
         incActive_q  <= incActive_d;
         incPending_q <= incPending_d;
         rf_q         <= rf_d;
      end
   end
endmodule

// File: tb/tb_fm_exciter.sv
`timescale 1ns/1ps
// tb_fm_exciter: directed, cycle-exact walk through ramp, sine, tuning, FIFO,
// deviation and reset behaviour with hand-computed expected values.
module tb_fm_exciter;
   localparam int A = 8, K = 4, N = 18, M = 14, D = 5, G = 4, DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   int   passCount = 0;
   int   failCount = 0;
   int   checkCount = 0;

   always #5 clk = ~clk;

   fm_exciter_if #(.A(A), .K(K), .N(N), .D(D)) bus ();

   fm_exciter #(.A(A), .K(K), .N(N), .M(M), .D(D), .G(G), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic applyStimulus(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      int rfWave [7] = '{28, 31, 27, 16, 4, 1, 5};

      rst             = 1'b1;
      bus.enable      = 1'b0;
      bus.sample_tick = 1'b0;
      bus.audio_data  = '0;
      bus.audio_valid = 1'b0;
      bus.acc_inc     = '0;
      bus.tune_load   = 1'b0;
      bus.df_coef     = '0;
      bus.df_shift    = '0;
      applyStimulus(2);
      rst = 1'b0;

      checkOutput("reset_rf", 32'(bus.rf), 32'd16);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("reset_ready", 32'(bus.audio_ready), 32'd1);
      checkOutput("reset_underflow", 32'(bus.underflow), 32'd0);
      checkOutput("reset_phase", 32'(dut.phase_q), 32'd0);

      // Tune while idle: pending then active one cycle later.
      bus.acc_inc   = 18'h08000;
      bus.tune_load = 1'b1;
      applyStimulus(1);
      bus.tune_load = 1'b0;
      applyStimulus(1);
      checkOutput("idle_tune", 32'(dut.incActive_q), 32'h8000);

      // Ramp up from amp 0 to full scale.
      bus.enable = 1'b1;
      applyStimulus(1);
      checkOutput("rampup_busy", 32'(bus.busy), 32'd1);
      checkOutput("rampup_amp0", 32'(dut.amp_q), 32'd0);
      checkOutput("rampup_rf_amp0", 32'(bus.rf), 32'd16);
      applyStimulus(1);
      checkOutput("rampup_rf_lag", 32'(bus.rf), 32'd16);
      checkOutput("rampup_amp1", 32'(dut.amp_q), 32'd1);
      for (int k = 2; k <= 16; k++) begin
         applyStimulus(1);
         checkOutput($sformatf("rampup_amp%0d", k), 32'(dut.amp_q), 32'(k));
      end
      checkOutput("run_busy", 32'(bus.busy), 32'd1);

      // Full-scale sine, phase step 0x8000 -> eight samples per period.
      applyStimulus(1);
      checkOutput("sine_ph0", 32'(bus.rf), 32'd16);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1);
         checkOutput($sformatf("sine_ph%0d", i + 1), 32'(bus.rf), 32'(rfWave[i]));
      end

      // Retune mid-period: takes effect only after the next wrap.
      applyStimulus(2);
      bus.acc_inc   = 18'h10000;
      bus.tune_load = 1'b1;
      applyStimulus(1);
      bus.tune_load = 1'b0;
      checkOutput("tune_hold0", 32'(dut.incActive_q), 32'h8000);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1);
         checkOutput($sformatf("tune_hold%0d", i), 32'(dut.incActive_q), 32'h8000);
      end
      applyStimulus(1);
      checkOutput("tune_after_wrap", 32'(dut.incActive_q), 32'h10000);
      checkOutput("tune_wrap_phase", 32'(dut.phase_q), 32'h0);
      applyStimulus(1);
      checkOutput("tune_new_step", 32'(dut.phase_q), 32'h10000);

      // Pop on an empty FIFO while running.
      bus.sample_tick = 1'b1;
      applyStimulus(1);
      bus.sample_tick = 1'b0;
      checkOutput("underflow_set", 32'(bus.underflow), 32'd1);
      checkOutput("underflow_sample", 32'(dut.sample_q), 32'h0);

      // Fill the FIFO; the fifth word must be refused.
      bus.audio_valid = 1'b1;
      bus.audio_data  = 8'h80;
      applyStimulus(1);
      checkOutput("push1_ready", 32'(bus.audio_ready), 32'd1);
      bus.audio_data = 8'h10;
      applyStimulus(1);
      bus.audio_data = 8'h20;
      applyStimulus(1);
      checkOutput("push3_ready", 32'(bus.audio_ready), 32'd1);
      bus.audio_data = 8'h30;
      applyStimulus(1);
      checkOutput("push4_full", 32'(bus.audio_ready), 32'd0);
      bus.audio_data = 8'h40;
      applyStimulus(1);
      checkOutput("push5_held", 32'(bus.audio_ready), 32'd0);
      bus.audio_valid = 1'b0;
      bus.sample_tick = 1'b1;
      applyStimulus(1);
      bus.sample_tick = 1'b0;
      checkOutput("pop_ready", 32'(bus.audio_ready), 32'd1);
      checkOutput("pop_sample", 32'(dut.sample_q), 32'h80);
      checkOutput("pop_phase", 32'(dut.phase_q), 32'h0);

      // Deviation: -128*15<<3 = -15360 = 0x3C400, plus step 0x10000.
      bus.df_coef  = 4'd15;
      bus.df_shift = 2'd3;
      applyStimulus(1);
      checkOutput("dev_step1", 32'(dut.phase_q), 32'h0C400);
      applyStimulus(1);
      checkOutput("dev_step2", 32'(dut.phase_q), 32'h18800);
      checkOutput("underflow_sticky", 32'(bus.underflow), 32'd1);
      bus.df_coef  = '0;
      bus.df_shift = '0;

      // Full ramp down from RUN to IDLE.
      bus.enable = 1'b0;
      applyStimulus(1);
      checkOutput("rampdown_amp16", 32'(dut.amp_q), 32'd16);
      applyStimulus(16);
      checkOutput("rampdown_amp0", 32'(dut.amp_q), 32'd0);
      checkOutput("rampdown_idle", 32'(bus.busy), 32'd0);
      applyStimulus(1);
      checkOutput("idle_rf", 32'(bus.rf), 32'd16);

      // sample_tick in IDLE is ignored.
      bus.sample_tick = 1'b1;
      applyStimulus(1);
      bus.sample_tick = 1'b0;
      checkOutput("idle_tick_sample", 32'(dut.sample_q), 32'h80);
      checkOutput("idle_underflow_kept", 32'(bus.underflow), 32'd1);

      // Re-enable clears underflow; reverse direction at amp 8.
      bus.enable = 1'b1;
      applyStimulus(1);
      checkOutput("reenable_underflow", 32'(bus.underflow), 32'd0);
      checkOutput("reenable_busy", 32'(bus.busy), 32'd1);
      applyStimulus(8);
      checkOutput("partial_amp8", 32'(dut.amp_q), 32'd8);
      bus.enable = 1'b0;
      applyStimulus(1);
      checkOutput("reverse_amp8", 32'(dut.amp_q), 32'd8);
      for (int k = 7; k >= 0; k--) begin
         applyStimulus(1);
         checkOutput($sformatf("reverse_amp%0d", k), 32'(dut.amp_q), 32'(k));
      end
      checkOutput("reverse_idle", 32'(bus.busy), 32'd0);
      applyStimulus(1);
      checkOutput("reverse_rf", 32'(bus.rf), 32'd16);

      // Drain retained FIFO words in order, then underflow and push-on-empty.
      bus.enable = 1'b1;
      applyStimulus(1);
      bus.sample_tick = 1'b1;
      applyStimulus(1);
      checkOutput("drain_w1", 32'(dut.sample_q), 32'h10);
      applyStimulus(1);
      checkOutput("drain_w2", 32'(dut.sample_q), 32'h20);
      applyStimulus(1);
      checkOutput("drain_w3", 32'(dut.sample_q), 32'h30);
      checkOutput("drain_no_underflow", 32'(bus.underflow), 32'd0);
      applyStimulus(1);
      checkOutput("drain_underflow", 32'(bus.underflow), 32'd1);
      checkOutput("drain_hold", 32'(dut.sample_q), 32'h30);
      bus.audio_valid = 1'b1;
      bus.audio_data  = 8'h55;
      applyStimulus(1);
      bus.audio_valid = 1'b0;
      checkOutput("empty_push_hold", 32'(dut.sample_q), 32'h30);
      applyStimulus(1);
      bus.sample_tick = 1'b0;
      checkOutput("empty_push_stored", 32'(dut.sample_q), 32'h55);

      // Asynchronous reset mid-operation discards queued audio.
      bus.audio_valid = 1'b1;
      bus.audio_data  = 8'h11;
      applyStimulus(1);
      bus.audio_data = 8'h22;
      applyStimulus(1);
      bus.audio_valid = 1'b0;
      rst = 1'b1;
      #2;
      checkOutput("async_rst_rf", 32'(bus.rf), 32'd16);
      checkOutput("async_rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("async_rst_amp", 32'(dut.amp_q), 32'd0);
      applyStimulus(1);
      rst = 1'b0;
      checkOutput("post_rst_ready", 32'(bus.audio_ready), 32'd1);
      checkOutput("post_rst_sample", 32'(dut.sample_q), 32'h0);
      applyStimulus(1);
      bus.sample_tick = 1'b1;
      applyStimulus(1);
      bus.sample_tick = 1'b0;
      checkOutput("post_rst_fifo_empty", 32'(bus.underflow), 32'd1);
      checkOutput("post_rst_sample_held", 32'(dut.sample_q), 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
